// File: rtl/histo_frame_serializer.sv
// Parallel-to-serial feeder for the run-length histogram stage: a 2-deep frame FIFO
// followed by a PULSE/LEAD/SHIFT/TAIL replay FSM with registered outputs.
module histo_frame_serializer #(
  parameter int unsigned SEQ_W = 16,
  parameter int unsigned LEAD  = 2,
  parameter int unsigned TAIL  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  output logic             frame_ready,
  input  logic [SEQ_W-1:0] frame_mask,
  input  logic [SEQ_W-1:0] frame_data,
  output logic             hist_int,
  output logic             data_valid,
  output logic             data_in,
  output logic             busy,
  output logic [15:0]      frames_sent
);

  localparam int unsigned IdxW   = $clog2(SEQ_W) + 1;
  localparam int unsigned SelW   = $clog2(SEQ_W);
  localparam int unsigned GapMax = (LEAD > TAIL) ? LEAD : TAIL;
  localparam int unsigned GapW   = $clog2(GapMax + 1);

  typedef enum logic [2:0] {StIdle, StPulse, StLead, StShift, StTail} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [SEQ_W-1:0] mask_q, mask_d, data_q, data_d;
  logic [15:0]      frames_sent_q, frames_sent_d;
  logic             hist_int_q, hist_int_d;
  logic             data_valid_q, data_valid_d;
  logic             data_in_q, data_in_d;
  logic             busy_q, busy_d;

  // Two-entry frame FIFO
  logic [SEQ_W-1:0] fifo_mask_q [2];
  logic [SEQ_W-1:0] fifo_data_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign frame_ready = (count_q != 2'd2);
  assign push        = frame_valid && frame_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mask_q[wr_ptr_q] <= frame_mask;
      fifo_data_q[wr_ptr_q] <= frame_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    mask_d        = mask_q;
    data_d        = data_q;
    frames_sent_d = frames_sent_q;
    pop           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (LEAD > 0) begin
          state_d = StLead;
          gap_d   = '0;
        end else begin
          state_d = StShift;
          idx_d   = '0;
        end
      end
      StLead: begin
        if (gap_q == GapW'(LEAD - 1)) begin
          state_d = StShift;
          idx_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StShift: begin
        if (idx_q == IdxW'(SEQ_W - 1)) begin
          state_d = StTail;
          gap_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StTail: begin
        if (gap_q == GapW'(TAIL - 1)) begin
          frames_sent_d = frames_sent_q + 16'd1;
          // Chain straight into the next frame so the period stays fixed
          if (count_q != 2'd0) begin
            pop     = 1'b1;
            state_d = StPulse;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      mask_d = fifo_mask_q[rd_ptr_q];
      data_d = fifo_data_q[rd_ptr_q];
    end
    // Outputs are decoded from the next state so they register in step with it
    hist_int_d   = (state_d == StPulse);
    data_valid_d = (state_d == StShift) && mask_d[idx_d[SelW-1:0]];
    data_in_d    = (state_d == StShift) && mask_d[idx_d[SelW-1:0]] && data_d[idx_d[SelW-1:0]];
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      gap_q         <= '0;
      mask_q        <= '0;
      data_q        <= '0;
      frames_sent_q <= 16'd0;
      hist_int_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      data_in_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      mask_q        <= mask_d;
      data_q        <= data_d;
      frames_sent_q <= frames_sent_d;
      hist_int_q    <= hist_int_d;
      data_valid_q  <= data_valid_d;
      data_in_q     <= data_in_d;
      busy_q        <= busy_d;
    end
  end

  assign hist_int    = hist_int_q;
  assign data_valid  = data_valid_q;
  assign data_in     = data_in_q;
  assign busy        = busy_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_histo_frame_serializer.sv
// Bench for histo_frame_serializer: a timeline model (queue + position within the frame
// period) predicts every output on every cycle under directed and random traffic.
module tb_histo_frame_serializer;

  localparam int SEQ_W  = 16;
  localparam int LEAD   = 2;
  localparam int TAIL   = 1;
  localparam int PERIOD = 1 + LEAD + SEQ_W + TAIL;

  typedef struct packed {
    logic [15:0] m;
    logic [15:0] d;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_mask;
  logic [15:0] frame_data;
  logic        hist_int;
  logic        data_valid;
  logic        data_in;
  logic        busy;
  logic [15:0] frames_sent;

  histo_frame_serializer #(
    .SEQ_W(SEQ_W),
    .LEAD (LEAD),
    .TAIL (TAIL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_mask (frame_mask),
    .frame_data (frame_data),
    .hist_int   (hist_int),
    .data_valid (data_valid),
    .data_in    (data_in),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  // Reference model: queued frames, and where the active frame is within its period
  frame_t      mq[$];
  bit          m_active;
  int          m_pos;
  frame_t      m_cur;
  logic [15:0] m_sent;
  bit          last_push;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit push, input frame_t f);
    if (r) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_sent   = 16'd0;
    end else begin
      if (m_active) begin
        m_pos++;
        if (m_pos == PERIOD) begin
          m_sent++;
          m_active = 1'b0;
        end
      end
      if (!m_active && mq.size() > 0) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (push) mq.push_back(f);
    end
  endtask

  task automatic check_all();
    int   slot;
    logic e_dv, e_di;
    slot = m_pos - 1 - LEAD;
    e_dv = 1'b0;
    e_di = 1'b0;
    if (m_active && slot >= 0 && slot < SEQ_W) begin
      e_dv = m_cur.m[slot];
      e_di = m_cur.m[slot] & m_cur.d[slot];
    end
    chk("hist_int", {15'd0, hist_int}, {15'd0, m_active && m_pos == 0});
    chk("data_valid", {15'd0, data_valid}, {15'd0, e_dv});
    chk("data_in", {15'd0, data_in}, {15'd0, e_di});
    chk("busy", {15'd0, busy}, {15'd0, m_active});
    chk("frames_sent", frames_sent, m_sent);
    chk("frame_ready", {15'd0, frame_ready}, {15'd0, mq.size() != 2});
  endtask

  task automatic tick();
    bit     push;
    bit     r;
    frame_t f;
    r         = rst;
    push      = frame_valid && !r && (mq.size() != 2);
    f.m       = frame_mask;
    f.d       = frame_data;
    last_push = push;
    @(posedge clk);
    model_step(r, push, f);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offers a frame until accepted; frame_valid is left high for the caller to drop
  task automatic send(input logic [15:0] m, input logic [15:0] d);
    frame_valid = 1'b1;
    frame_mask  = m;
    frame_data  = d;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_push) break;
    end
    chk("send_accepted", {15'd0, last_push}, 16'd1);
  endtask

  logic [15:0] five_masks [5];

  initial begin
    rst         = 1'b1;
    frame_valid = 1'b0;
    frame_mask  = 16'h0;
    frame_data  = 16'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single frame
    send(16'h000C, 16'h0000);
    frame_valid = 1'b0;
    idle(25);
    chk("single_sent", frames_sent, 16'd1);

    // Five queued frames with valid held high
    five_masks[0] = 16'h000C;
    five_masks[1] = 16'h0070;
    five_masks[2] = 16'h0010;
    five_masks[3] = 16'h00FF;
    five_masks[4] = 16'h00C0;
    for (int i = 0; i < 5; i++) send(five_masks[i], 16'h0000);
    frame_valid = 1'b0;
    idle(110);
    chk("five_sent", frames_sent, 16'd6);

    // Data masking
    send(16'h00F0, 16'hFFFF);
    frame_valid = 1'b0;
    idle(25);
    chk("mask_sent", frames_sent, 16'd7);

    // Reset while slot 5 of a full-mask frame is on the line
    send(16'hFFFF, 16'hA5A5);
    frame_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_active && m_pos == 1 + LEAD + 5) break;
      tick();
    end
    chk("reached_slot5", {15'd0, data_valid}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_sent", frames_sent, 16'd0);
    chk("rst_ready", {15'd0, frame_ready}, 16'd1);
    idle(25);

    // Full-mask frame followed back-to-back by a top-bit-only frame
    send(16'hFFFF, 16'h1234);
    send(16'h8000, 16'hFFFF);
    frame_valid = 1'b0;
    idle(45);
    chk("boundary_sent", frames_sent, 16'd2);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      frame_valid = ($urandom_range(0, 3) != 0);
      frame_mask  = 16'($urandom);
      frame_data  = 16'($urandom);
      rst         = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst         = 1'b0;
    frame_valid = 1'b0;
    idle(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
